// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: FSM states, read-tag/owner encoding
// and the burst counter width.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW_OWN,
        ST_HOST_OWN
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_DRAW,
        TAG_HOST
    } tag_t;

    localparam int unsigned BCW = 4;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of requester, timing and VRAM-macro signals around the arbiter.
// slave = arbiter side, master = requesters + VRAM side.
interface vram_arbiter_if #(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 16
);
    logic          VBLANK;

    logic          DISP_REQ;
    logic [AW-1:0] DISP_ADDR;
    logic          DISP_RVALID;
    logic [DW-1:0] DISP_RDATA;

    logic          DRAW_REQ;
    logic          DRAW_WE;
    logic [AW-1:0] DRAW_ADDR;
    logic [DW-1:0] DRAW_WDATA;
    logic          DRAW_GNT;
    logic          DRAW_RVALID;
    logic [DW-1:0] DRAW_RDATA;

    logic          HOST_REQ;
    logic          HOST_WE;
    logic [AW-1:0] HOST_ADDR;
    logic [DW-1:0] HOST_WDATA;
    logic          HOST_GNT;
    logic          HOST_RVALID;
    logic [DW-1:0] HOST_RDATA;

    logic          MEM_EN;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;

    modport slave (
        input  VBLANK,
        input  DISP_REQ, DISP_ADDR,
        output DISP_RVALID, DISP_RDATA,
        input  DRAW_REQ, DRAW_WE, DRAW_ADDR, DRAW_WDATA,
        output DRAW_GNT, DRAW_RVALID, DRAW_RDATA,
        input  HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
        output HOST_GNT, HOST_RVALID, HOST_RDATA,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA
    );

    modport master (
        output VBLANK,
        output DISP_REQ, DISP_ADDR,
        input  DISP_RVALID, DISP_RDATA,
        output DRAW_REQ, DRAW_WE, DRAW_ADDR, DRAW_WDATA,
        input  DRAW_GNT, DRAW_RVALID, DRAW_RDATA,
        output HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
        input  HOST_GNT, HOST_RVALID, HOST_RDATA,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA
    );

endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: DISP has absolute priority with fixed 1-cycle read
// latency; DRAW and HOST share the remaining slots round-robin in bursts.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned AW               = 17,
    parameter int unsigned DW               = 16,
    parameter int unsigned BURST            = 4,
    parameter bit          HOST_VBLANK_ONLY = 1'b0
) (
    input  logic           CLK,
    input  logic           RST,
    vram_arbiter_if.slave  bus
);

    localparam logic [BCW-1:0] LP_BURST = BCW'(BURST);
    localparam logic [BCW-1:0] LP_ONE   = BCW'(1);

    state_t         r_state;
    logic [BCW-1:0] r_burst_cnt;
    tag_t           r_rr_last;
    tag_t           r_tag;

    logic w_draw_elig;
    logic w_host_elig;
    logic w_cont_draw;
    logic w_cont_host;
    logic w_new_burst;
    logic w_gnt_draw;
    logic w_gnt_host;
    tag_t w_tag_nxt;

    // The owner of an exhausted or abandoned burst always equals r_rr_last,
    // so falling back to plain IDLE arbitration puts it at lowest priority.
    always_comb begin
        w_draw_elig = bus.DRAW_REQ;
        w_host_elig = bus.HOST_REQ && (!HOST_VBLANK_ONLY || bus.VBLANK);
        w_cont_draw = (r_state == ST_DRAW_OWN) && w_draw_elig && (r_burst_cnt < LP_BURST);
        w_cont_host = (r_state == ST_HOST_OWN) && w_host_elig && (r_burst_cnt < LP_BURST);
        w_new_burst = 1'b0;
        w_gnt_draw  = 1'b0;
        w_gnt_host  = 1'b0;
        if (RST && !bus.DISP_REQ) begin
            if (w_cont_draw) begin
                w_gnt_draw = 1'b1;
            end else if (w_cont_host) begin
                w_gnt_host = 1'b1;
            end else begin
                w_new_burst = 1'b1;
                if (w_draw_elig && (!w_host_elig || r_rr_last == TAG_HOST)) begin
                    w_gnt_draw = 1'b1;
                end else if (w_host_elig) begin
                    w_gnt_host = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.MEM_EN    = 1'b0;
        bus.MEM_WE    = 1'b0;
        bus.MEM_ADDR  = '0;
        bus.MEM_WDATA = '0;
        w_tag_nxt     = TAG_NONE;
        if (RST && bus.DISP_REQ) begin
            bus.MEM_EN   = 1'b1;
            bus.MEM_ADDR = bus.DISP_ADDR;
            w_tag_nxt    = TAG_DISP;
        end else if (w_gnt_draw) begin
            bus.MEM_EN    = 1'b1;
            bus.MEM_WE    = bus.DRAW_WE;
            bus.MEM_ADDR  = bus.DRAW_ADDR;
            bus.MEM_WDATA = bus.DRAW_WDATA;
            w_tag_nxt     = bus.DRAW_WE ? TAG_NONE : TAG_DRAW;
        end else if (w_gnt_host) begin
            bus.MEM_EN    = 1'b1;
            bus.MEM_WE    = bus.HOST_WE;
            bus.MEM_ADDR  = bus.HOST_ADDR;
            bus.MEM_WDATA = bus.HOST_WDATA;
            w_tag_nxt     = bus.HOST_WE ? TAG_NONE : TAG_HOST;
        end
    end

    always_comb begin
        bus.DRAW_GNT    = w_gnt_draw;
        bus.HOST_GNT    = w_gnt_host;
        bus.DISP_RVALID = (r_tag == TAG_DISP);
        bus.DRAW_RVALID = (r_tag == TAG_DRAW);
        bus.HOST_RVALID = (r_tag == TAG_HOST);
        bus.DISP_RDATA  = bus.DISP_RVALID ? bus.MEM_RDATA : '0;
        bus.DRAW_RDATA  = bus.DRAW_RVALID ? bus.MEM_RDATA : '0;
        bus.HOST_RDATA  = bus.HOST_RVALID ? bus.MEM_RDATA : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
            r_rr_last   <= TAG_HOST;
            r_tag       <= TAG_NONE;
        end else begin
            r_tag <= w_tag_nxt;
            // A DISP cycle freezes the burst so a preempted owner resumes.
            if (!bus.DISP_REQ) begin
                if (w_gnt_draw) begin
                    r_state     <= ST_DRAW_OWN;
                    r_rr_last   <= TAG_DRAW;
                    r_burst_cnt <= w_new_burst ? LP_ONE : r_burst_cnt + LP_ONE;
                end else if (w_gnt_host) begin
                    r_state     <= ST_HOST_OWN;
                    r_rr_last   <= TAG_HOST;
                    r_burst_cnt <= w_new_burst ? LP_ONE : r_burst_cnt + LP_ONE;
                end else begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between three requesters: display fetch (DISP), draw engine (DRAW) and host CPU (HOST).
- DISP has absolute priority and fixed latency, so the scan-out path driven by the sync/timing generator never stalls.
- DRAW and HOST are served round-robin, in short bursts, using the remaining bandwidth (blanking intervals plus idle pixel slots).
- Sits between the timing/scan-out logic, the drawing datapath and the VRAM macro.

Parameters:
- AW, 17, VRAM word address width.
- DW, 16, VRAM data width.
- BURST, 4, max consecutive grants to one of DRAW/HOST before re-arbitration (range 1..15).
- HOST_VBLANK_ONLY, 0, when 1 HOST is eligible only while VBLANK=1.

Ports:
- CLK  in  1  system clock (2x pixel clock).
- RST  in  1  asynchronous, active-low reset.
- VBLANK  in  1  vertical blanking flag from timing logic.
- DISP_REQ  in  1  display read strobe, one cycle per word.
- DISP_ADDR  in  AW  display read address.
- DISP_RVALID  out  1  display read data valid.
- DISP_RDATA  out  DW  display read data.
- DRAW_REQ  in  1  draw request; held until granted.
- DRAW_WE  in  1  1 = write, 0 = read.
- DRAW_ADDR  in  AW  draw address.
- DRAW_WDATA  in  DW  draw write data.
- DRAW_GNT  out  1  draw access accepted this cycle.
- DRAW_RVALID  out  1  draw read data valid.
- DRAW_RDATA  out  DW  draw read data.
- HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA, HOST_GNT, HOST_RVALID, HOST_RDATA: same widths and meaning as the DRAW ports.
- MEM_EN  out  1  VRAM access enable.
- MEM_WE  out  1  VRAM write enable.
- MEM_ADDR  out  AW  VRAM address.
- MEM_WDATA  out  DW  VRAM write data.
- MEM_RDATA  in  DW  VRAM read data, valid the cycle after the access.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, burst_cnt=0, rr_last=HOST (so DRAW wins the first contention), read tag cleared.
  - All RVALID=0, all GNT=0, MEM_EN=0, MEM_WE=0 while RST=0.
- Timing:
  - Grants and MEM_* outputs are combinational from the REQ inputs and registered state.
  - The access is sampled by VRAM at the end of grant cycle t.
  - Read data appears in cycle t+1. The owner's xx_RVALID is registered high in t+1 and xx_RDATA = MEM_RDATA in that cycle.
  - Write grants produce no RVALID.
- Eligibility:
  - DRAW eligible = DRAW_REQ.
  - HOST eligible = HOST_REQ && (!HOST_VBLANK_ONLY || VBLANK).
- DISP_REQ=1: MEM_EN=1, MEM_WE=0, MEM_ADDR=DISP_ADDR in that same cycle, always. No DRAW/HOST grant that cycle. DISP_RVALID=1 next cycle (fixed latency 1).
- FSM states: IDLE, DRAW_OWN, HOST_OWN.
  - IDLE, no DISP_REQ: grant the eligible requester. If both are eligible, grant the one not equal to rr_last. Go to X_OWN with burst_cnt=1 and rr_last=X. If nothing is eligible, stay in IDLE with MEM_EN=0.
  - X_OWN with DISP_REQ: X is preempted. No grant, state and burst_cnt are held.
  - X_OWN, X eligible and burst_cnt<BURST: grant X, burst_cnt++.
  - X_OWN, X not eligible or burst_cnt==BURST: the cycle is arbitrated exactly as IDLE with X at lowest priority (no bubble cycle). X may be re-granted only if the other requester is not eligible; that starts a new burst with burst_cnt=1.
  - HOST_OWN with HOST_VBLANK_ONLY=1 and VBLANK falling: HOST is no longer eligible, so the burst ends that cycle.
- Write grant: MEM_WE=1, MEM_WDATA from the owner. A read-after-write to the same address in the next grant returns the new data (VRAM property; the arbiter adds no forwarding).
- Read tag: a 2-bit registered tag {NONE, DISP, DRAW, HOST} of the last read routes MEM_RDATA. Exactly one RVALID is high per cycle, at most.
- burst_cnt width: 4 bits, saturating at BURST.
- Reset mid-burst: all outputs deassert immediately. An in-flight read's RVALID is suppressed.

Decomposition:
- Package vram_arb_pkg: state enum (IDLE, DRAW_OWN, HOST_OWN), owner/tag enum (NONE, DISP, DRAW, HOST), burst counter width constant.
- No sub-module. A single module holds the FSM, counter, rr pointer and read-tag pipeline.

Test Plan:
- Reset: assert RST=0 with DRAW_REQ=1 -> DRAW_GNT=0, MEM_EN=0. Release -> first DRAW_GNT in the next cycle.
- DISP priority: DISP_REQ=1 at addr 0x00100 while DRAW_REQ is held -> DRAW_GNT=0 that cycle, MEM_ADDR=0x00100. Next cycle DISP_RVALID=1 with the preloaded word 0xA5A5; DRAW is granted.
- Burst/round-robin: DRAW and HOST both held continuously, BURST=4 -> grant pattern D,D,D,D,H,H,H,H,D... with no idle cycles.
- Preemption mid-burst: DISP_REQ in the 2nd DRAW grant cycle -> DRAW burst resumes afterwards and still gets 4 total grants before HOST.
- HOST_VBLANK_ONLY=1: HOST_REQ held while VBLANK=0 -> no HOST_GNT. VBLANK rises -> HOST_GNT within 1 cycle. VBLANK falls mid-burst -> HOST_GNT drops the same cycle.
- Read routing: HOST read of 0x1FFFF (preloaded 0x1234) -> HOST_RVALID=1, HOST_RDATA=0x1234 one cycle later, DRAW_RVALID/DISP_RVALID=0.
